rx_buf_rd_arbiter: RTL
======================

RX_BUF_RD_ARBITER -- requirements
Module: rx_buf_rd_arbiter

Interface
REQ-001 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high; resets all state.
REQ-003 SHALL have ports req0/req1  in  1 each  read request, held high until doneN.
REQ-004 SHALL have ports req0_addr/req1_addr  in  11 each  burst start address in rx buffer.
REQ-005 SHALL have ports req0_len/req1_len  in  8 each  burst length in bytes, legal 1..128.
REQ-006 SHALL have ports gnt0/gnt1  out  1 each  high for the whole owned burst.
REQ-007 SHALL have ports rd_valid0/rd_valid1  out  1 each  qualifies rd_data for that requester.
REQ-008 SHALL have port rd_data  out  8  registered copy of rx_buf_rdata.
REQ-009 SHALL have ports done0/done1  out  1 each  one-cycle burst-complete pulse.
REQ-010 SHALL have ports rx_buf_rden  out  1 and rx_buf_raddr  out  11  shared rx buffer read port.
REQ-011 SHALL have port rx_buf_rdata  in  8  buffer data, valid 2 cycles after rden/raddr.
REQ-012 SHALL have ports rx_start/rx_done  in  1 each  link frame start/end levels from link layer.
REQ-013 SHALL have ports len_err  out  1  and rd_abort  out  1  one-cycle error pulses coincident with doneN.

Function
REQ-014 SHALL register rx_start/rx_done through 2-bit edge shifters; link_busy sets on rx_start rising edge and clears on rx_done rising edge; simultaneous rising edges leave link_busy cleared.
REQ-015 SHALL implement states IDLE, GRANT, READ, DRAIN, DONE.
REQ-016 IDLE: when link_busy=0 and any reqN=1, go to GRANT; with both requesting, grant the requester not granted last (round-robin pointer, reset value favours req0).
REQ-017 GRANT (1 cycle): latch address and length of the winner, assert gntN; go to READ; len=0 goes directly to DONE with len_err; len>128 clamps to 128 with len_err pulsed at DONE.
REQ-018 READ: assert rx_buf_rden one cycle per byte, raddr = start + beat index modulo 2048 (2047 wraps to 0); after the last beat go to DRAIN.
REQ-019 DRAIN: wait for 2-cycle read latency; rd_validN high exactly for cycles where returned data belongs to the burst; total rd_validN pulses = effective length.
REQ-020 DONE (1 cycle): pulse doneN, drop gntN and rden, update round-robin pointer, return to IDLE.
REQ-021 A rx_start rising edge during GRANT/READ/DRAIN SHALL not stop the burst; rd_abort SHALL pulse at DONE to flag possibly overwritten data.
REQ-022 Requester deasserting reqN mid-burst SHALL be ignored; burst completes.
REQ-023 A new grant SHALL NOT be issued in the same cycle as DONE (minimum one IDLE cycle between bursts).
REQ-024 gnt0 and gnt1 SHALL never be high together; rd_valid0 and rd_valid1 SHALL never be high together.
REQ-025 Latency: first rden SHALL be 2 cycles after req rises in IDLE; first rd_validN SHALL be 3 cycles after first rden (2-cycle buffer latency + output register).

Reset
REQ-026 On reset: state IDLE, all outputs 0 (gnt, rd_valid, done, rden, raddr=0, rd_data=0, len_err, rd_abort), link_busy=0, pointer favours req0.
REQ-027 Reset asserted mid-burst SHALL abort immediately with no doneN pulse; after release the block waits in IDLE for reqN.

Verification
REQ-028 req0 with addr=4, len=5 -> gnt0, raddr 4..8 on 5 consecutive rden cycles, 5 rd_valid0 with data of addresses 4..8, done0 single pulse.
REQ-029 req0 and req1 asserted together twice in a row -> first grant gnt0, second gnt1; gnts never overlap.
REQ-030 req1 with addr=2046, len=4 -> raddr sequence 2046, 2047, 0, 1.
REQ-031 req0 len=0 -> no rden, len_err and done0 pulse together; len=200 -> 128 reads, len_err at done0.
REQ-032 rx_start rise while idle with req0 pending -> no grant until rx_done rise; rx_start rise mid-burst -> burst completes, rd_abort with done0.
REQ-033 reset asserted during READ -> all outputs 0 next edge, no done0; new req0 afterwards served normally.

Source files
------------

// File: rtl/rx_buf_rd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rx_buf_rd_arbiter
// Purpose  : Two-requester round-robin arbiter for the shared rx buffer read
//            port. The winner owns the port for one burst of 1..128 bytes.
//            Each returned byte is delivered through a registered rd_data
//            and qualified by that requester's rd_validN. New bursts start
//            only while the link layer is not writing a frame.
// Ports    : clk, reset                 - clock, async active-high reset
//            req0/1, req0/1_addr, _len  - burst requests (held until doneN)
//            gnt0/1                     - burst ownership
//            rd_valid0/1, rd_data       - returned data and its qualifiers
//            done0/1, len_err, rd_abort - end-of-burst status pulses
//            rx_buf_rden/raddr/rdata    - rx buffer read port (2-cycle latency)
//            rx_start, rx_done          - link frame start/end levels
// Revision : 1.0 - initial release
// ============================================================================
module rx_buf_rd_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [10:0] req0_addr,
  input  logic [10:0] req1_addr,
  input  logic [7:0]  req0_len,
  input  logic [7:0]  req1_len,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rd_valid0,
  output logic        rd_valid1,
  output logic [7:0]  rd_data,
  output logic        done0,
  output logic        done1,
  output logic        rx_buf_rden,
  output logic [10:0] rx_buf_raddr,
  input  logic [7:0]  rx_buf_rdata,
  input  logic        rx_start,
  input  logic        rx_done,
  output logic        len_err,
  output logic        rd_abort
);

  localparam logic [7:0] c_MAX_LEN = 8'd128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_owner;       // 0: requester 0 owns the burst, 1: requester 1
  logic        r_last;        // requester granted most recently
  logic [10:0] r_addr;
  logic [7:0]  r_len;         // effective (clamped) burst length
  logic [7:0]  r_beat;
  logic        r_len_err;
  logic        r_abort;
  logic [1:0]  r_start_sh;
  logic [1:0]  r_done_sh;
  logic        r_link_busy;
  logic [1:0]  r_rd_pipe;     // tracks rden through the buffer's 2-cycle latency
  logic        r_rd_valid;
  logic [7:0]  r_rd_data;

  logic        w_start_rise;
  logic        w_done_rise;
  logic        w_winner;
  logic [10:0] w_sel_addr;
  logic [7:0]  w_sel_len;
  logic [7:0]  w_eff_len;
  logic        w_last_beat;
  logic        w_in_burst;

  assign w_start_rise = r_start_sh[0] & ~r_start_sh[1];
  assign w_done_rise  = r_done_sh[0]  & ~r_done_sh[1];

  // Only a contested cycle consults the round-robin pointer.
  assign w_winner   = (req0 & req1) ? ~r_last : req1;
  assign w_sel_addr = r_owner ? req1_addr : req0_addr;
  assign w_sel_len  = r_owner ? req1_len  : req0_len;
  assign w_eff_len  = (w_sel_len > c_MAX_LEN) ? c_MAX_LEN : w_sel_len;
  assign w_last_beat = (r_beat == (r_len - 8'd1));
  assign w_in_burst  = (r_state == GRANT) || (r_state == READ) || (r_state == DRAIN);

  // Beat index is at most 127, so the 11-bit sum wraps 2047 -> 0 naturally.
  assign rx_buf_raddr = r_addr + {3'b000, r_beat};
  assign rd_data      = r_rd_data;
  assign rd_valid0    = r_rd_valid & ~r_owner;
  assign rd_valid1    = r_rd_valid &  r_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    rx_buf_rden  = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    len_err      = 1'b0;
    rd_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_link_busy && (req0 || req1)) begin
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        gnt0 = ~r_owner;
        gnt1 =  r_owner;
        w_state_next = (w_sel_len == 8'd0) ? DONE : READ;
      end
      READ: begin
        gnt0        = ~r_owner;
        gnt1        =  r_owner;
        rx_buf_rden = 1'b1;
        if (w_last_beat) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        gnt0 = ~r_owner;
        gnt1 =  r_owner;
        // Last byte is on rd_data in the cycle the pipe first reads empty.
        if (r_rd_pipe == 2'b00) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done0        = ~r_owner;
        done1        =  r_owner;
        len_err      = r_len_err;
        rd_abort     = r_abort;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_addr      <= 11'd0;
      r_len       <= 8'd0;
      r_beat      <= 8'd0;
      r_len_err   <= 1'b0;
      r_abort     <= 1'b0;
      r_start_sh  <= 2'b00;
      r_done_sh   <= 2'b00;
      r_link_busy <= 1'b0;
      r_rd_pipe   <= 2'b00;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 8'd0;
    end else begin
      r_start_sh <= {r_start_sh[0], rx_start};
      r_done_sh  <= {r_done_sh[0],  rx_done};

      // Coincident start and end edges resolve to "not busy".
      if (w_done_rise) begin
        r_link_busy <= 1'b0;
      end else if (w_start_rise) begin
        r_link_busy <= 1'b1;
      end

      r_rd_pipe  <= {r_rd_pipe[0], rx_buf_rden};
      r_rd_valid <= r_rd_pipe[1];
      r_rd_data  <= rx_buf_rdata;

      if ((r_state == IDLE) && (w_state_next == GRANT)) begin
        r_owner   <= w_winner;
        r_len_err <= 1'b0;
        r_abort   <= 1'b0;
      end

      if (r_state == GRANT) begin
        r_addr    <= w_sel_addr;
        r_len     <= w_eff_len;
        r_beat    <= 8'd0;
        r_len_err <= (w_sel_len == 8'd0) || (w_sel_len > c_MAX_LEN);
      end

      if ((r_state == READ) && !w_last_beat) begin
        r_beat <= r_beat + 8'd1;
      end

      if (r_state == DONE) begin
        r_last <= r_owner;
      end

      // The link may overwrite buffer contents under an active burst.
      if (w_start_rise && w_in_burst) begin
        r_abort <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
